// File: rtl/pipeline_reg.sv
// rtl/pipeline_reg.sv - single-entry valid/ready register slice
// One beat of storage with a one-cycle latency; full throughput when downstream is ready.
module pipeline_reg #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready
);

   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  push, pop;

   always_comb begin
      // Accept when empty, or when the held beat leaves on this same edge.
      in_ready = !rst && (!valid_q || out_ready);
      push     = in_valid && in_ready;
      pop      = valid_q && out_ready;
      data_d   = data_q;
      valid_d  = valid_q;
      if (push) begin
         data_d  = in_data;
         valid_d = 1'b1;
      end else if (pop) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign out_data  = data_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_pipeline_reg.sv
// tb/tb_pipeline_reg.sv - directed and random checks of pipeline_reg against a queue model
module tb_pipeline_reg;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;

   int nvec = 0;
   int nerr = 0;

   // Reference: a capacity-one FIFO plus the last value written into the slot.
   logic [7:0] mq[$];
   logic [7:0] m_last;
   logic [7:0] m_pops[$];
   logic [7:0] dut_pops[$];
   int         base;

   pipeline_reg #(.DATA_WIDTH(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .out_data (out_data),
      .out_valid(out_valid),
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      assert (got === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cycle(input logic r, input logic iv, input logic [7:0] d, input logic ordy);
      logic exp_ready;
      rst       = r;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      @(negedge clk);
      exp_ready = !r && (mq.size() == 0 || ordy);
      chk("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
      chk("out_valid", {31'b0, out_valid}, {31'b0, mq.size() != 0});
      chk("out_data", {24'b0, out_data}, {24'b0, (mq.size() != 0) ? mq[0] : m_last});
      if (!r && out_valid === 1'b1 && ordy) dut_pops.push_back(out_data);
      if (r) begin
         mq.delete();
         m_last = 8'h00;
      end else begin
         if (mq.size() != 0 && ordy) m_pops.push_back(mq.pop_front());
         if (iv && exp_ready) begin
            mq.push_back(d);
            m_last = d;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
      m_last = 8'h00;
      @(posedge clk);
      #1;

      // Reset held two cycles, even with traffic offered.
      cycle(1, 1, 8'h55, 1);
      cycle(1, 0, 8'h00, 0);
      chk("rst_data", {24'b0, out_data}, 32'h00);
      cycle(0, 0, 8'h00, 0);

      // Push then pop.
      base = dut_pops.size();
      cycle(0, 1, 8'hA5, 0);
      chk("push_valid", {31'b0, out_valid}, 32'h1);
      chk("push_data", {24'b0, out_data}, 32'hA5);
      cycle(0, 1, 8'h77, 0);
      cycle(0, 0, 8'h00, 1);
      cycle(0, 0, 8'h00, 0);
      chk("pp_npop", dut_pops.size() - base, 1);
      chk("pp_pop", {24'b0, (dut_pops.size() > base) ? dut_pops[base] : 8'hxx}, 32'hA5);

      // Backpressure.
      base = dut_pops.size();
      cycle(0, 1, 8'h3C, 0);
      cycle(0, 0, 8'h00, 0);
      cycle(0, 1, 8'h99, 0);
      cycle(0, 0, 8'h00, 1);
      cycle(0, 0, 8'h00, 1);
      chk("bp_npop", dut_pops.size() - base, 1);
      chk("bp_pop", {24'b0, (dut_pops.size() > base) ? dut_pops[base] : 8'hxx}, 32'h3C);

      // Pass-through.
      base = dut_pops.size();
      cycle(0, 1, 8'hF0, 1);
      cycle(0, 0, 8'h00, 1);
      cycle(0, 0, 8'h00, 1);
      chk("pt_npop", dut_pops.size() - base, 1);

      // Streaming three beats back to back.
      base = dut_pops.size();
      cycle(0, 1, 8'h10, 1);
      cycle(0, 1, 8'h21, 1);
      cycle(0, 1, 8'h32, 1);
      cycle(0, 0, 8'h00, 1);
      cycle(0, 0, 8'h00, 1);
      chk("st_npop", dut_pops.size() - base, 3);
      chk("st_order", {8'h0,
                       (dut_pops.size() > base + 2) ? dut_pops[base]   : 8'hxx,
                       (dut_pops.size() > base + 2) ? dut_pops[base+1] : 8'hxx,
                       (dut_pops.size() > base + 2) ? dut_pops[base+2] : 8'hxx}, 32'h00102132);

      // Reset while a beat is held under backpressure discards it.
      base = dut_pops.size();
      cycle(0, 1, 8'h3C, 0);
      cycle(0, 0, 8'h00, 0);
      cycle(1, 0, 8'h00, 0);
      chk("mr_data", {24'b0, out_data}, 32'h00);
      cycle(0, 0, 8'h00, 1);
      cycle(0, 0, 8'h00, 1);
      chk("mr_npop", dut_pops.size() - base, 0);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 49) == 0), $urandom_range(0, 1), 8'($urandom), ($urandom_range(0, 3) != 0));
      end
      cycle(0, 0, 8'h00, 1);

      chk("pop_count", dut_pops.size(), m_pops.size());
      for (int i = 0; i < m_pops.size(); i++) begin
         chk("pop_seq", {24'b0, (i < dut_pops.size()) ? dut_pops[i] : 8'hxx}, {24'b0, m_pops[i]});
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/pipeline_reg.md
PIPELINE_REG -- requirements
Module: pipeline_reg

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the payload width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_data, input, DATA_WIDTH bits: upstream payload.
REQ-005 The block SHALL have port in_valid, input, 1 bit: upstream offers in_data this cycle.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block can accept a beat this cycle.
REQ-007 The block SHALL have port out_data, output, DATA_WIDTH bits: registered payload to downstream.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_data holds a valid beat.
REQ-009 The block SHALL have port out_ready, input, 1 bit: downstream accepts out_data this cycle.

Function
REQ-010 The block SHALL be a single-entry register slice; storage is exactly one DATA_WIDTH entry plus its valid flag (out_valid).
REQ-011 A push SHALL occur on a rising edge where in_valid && in_ready; a pop SHALL occur on a rising edge where out_valid && out_ready.
REQ-012 in_ready SHALL be combinational: in_ready = !rst && (!out_valid || out_ready), i.e. ready when empty or when the held beat pops this cycle.
REQ-013 out_data and out_valid SHALL be driven directly from registers; no combinational path from in_data/in_valid to out_data/out_valid.
REQ-014 Latency SHALL be exactly one cycle: a beat pushed at edge N is presented with out_valid=1 from just after edge N.
REQ-015 Push while empty: the entry SHALL load in_data and out_valid SHALL go to 1.
REQ-016 Pop without push: out_valid SHALL go to 0; out_data SHALL keep its last value (don't-care content while invalid).
REQ-017 Simultaneous push and pop (occupied, out_ready=1, in_valid=1): the entry SHALL be replaced by the new in_data and out_valid SHALL stay 1, sustaining one beat per cycle.
REQ-018 Backpressure (out_valid=1, out_ready=0): out_data and out_valid SHALL hold stable every cycle until a pop; in_ready SHALL be 0 and no push SHALL occur.
REQ-019 Idle (empty, in_valid=0): state SHALL remain empty.
REQ-020 Beats SHALL be delivered in push order with no loss and no duplication.
REQ-021 out_valid, once asserted, SHALL NOT deassert without a pop or reset (AXI-style valid stability).
REQ-022 in_data SHALL be ignored when in_valid=0 or in_ready=0.

Reset
REQ-023 While rst=1 at a rising edge, out_valid SHALL become 0 and out_data SHALL become 0.
REQ-024 While rst=1, in_ready SHALL be 0 and no push or pop SHALL occur.
REQ-025 Reset asserted while a beat is held SHALL discard that beat; after rst deasserts, the block SHALL be empty with in_ready=1.

Verification
REQ-026 Reset: hold rst=1 two cycles -> out_valid=0, out_data=0x00, in_ready=0; release -> in_ready=1.
REQ-027 Push then pop: one cycle in_valid=1, in_data=0xA5, out_ready=0 -> next cycle out_valid=1, out_data=0xA5, in_ready=0; then out_ready=1, in_valid=0 -> pop of 0xA5 at next edge, out_valid=0 after.
REQ-028 Backpressure: push 0x3C with out_ready=0, then in_valid=0 for 2 cycles -> out_data=0x3C, out_valid=1 stable each cycle; raise out_ready -> single pop of 0x3C, then empty.
REQ-029 Pass-through: empty, in_valid=1, in_data=0xF0, out_ready=1 for one cycle -> out_valid=1, out_data=0xF0 next cycle; popped the following edge, then empty.
REQ-030 Streaming: in_valid=1, out_ready=1, in_data=0x10,0x21,0x32 on consecutive cycles -> in_ready stays 1; out_data=0x10,0x21,0x32 on consecutive cycles one cycle later; then empty.
REQ-031 Reset mid-operation: hold 0x3C under backpressure, assert rst one cycle -> out_valid=0, out_data=0x00; 0x3C never popped.
